pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline.
- Decides each cycle whether the ID/EX register loads, holds or takes a bubble through its zeroing Stall input.
- Drives hold and flush of PC, IF/ID and EX/MEM.
- Selects ID-stage operand forwarding for ALUA/DataBusB.
- Sequences external-interrupt entry, tracks slow data-memory waits with a timeout, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   FWD_* : operand forwarding select values for FwdA/FwdB
//   state_t : memory-wait sequencing FSM state
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned TCNT_W = 16;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage source operand.
//   src           : source register read in ID
//   en            : operand is actually read (else regfile select)
//   ex/mem/wb_*   : destination register and write enable per stage
//   sel           : FWD_EX > FWD_MEM > FWD_WB > FWD_RF, $0 never forwarded
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             en,
  input  logic [REG_W-1:0] ex_addr,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] mem_addr,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] wb_addr,
  input  logic             wb_wr,
  output logic [FWD_W-1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (en && src != '0) begin
      if (ex_wr && ex_addr == src)
        sel = FWD_EX;
      else if (mem_wr && mem_addr == src)
        sel = FWD_MEM;
      else if (wb_wr && wb_addr == src)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
//   Inputs : per-stage register addresses/write enables, load flag in EX,
//            branch/jump resolution, IRQ level, MemBusy from data memory.
//   Outputs: hold/flush/bubble controls (combinational), FwdA/FwdB selects,
//            IrqTake pulse, sticky MemErr, saturating StallCnt/FlushCnt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic [REG_W-1:0] EX_AddrC,
  input  logic             EX_RegWr,
  input  logic             EX_MemRd,
  input  logic [REG_W-1:0] MEM_AddrC,
  input  logic             MEM_RegWr,
  input  logic [REG_W-1:0] WB_AddrC,
  input  logic             WB_RegWr,
  input  logic             EX_BranchTaken,
  input  logic             ID_Jump,
  input  logic             IRQ,
  input  logic             MemBusy,
  output logic             PC_Hold,
  output logic             IFID_Hold,
  output logic             IFID_Flush,
  output logic             IDEX_Hold,
  output logic             IDEX_Stall,
  output logic             EXMEM_Hold,
  output logic             MEMWB_Bubble,
  output logic [FWD_W-1:0] FwdA,
  output logic [FWD_W-1:0] FwdB,
  output logic             IrqTake,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [TCNT_W-1:0] TIMEOUT = TCNT_W'(MEM_TIMEOUT);

  state_t            state;
  logic              irq_prev;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_inc;
  logic              irq_edge;
  logic              load_use;
  logic              irq_upd;
  logic [FWD_W-1:0]  fwda_raw;
  logic [FWD_W-1:0]  fwdb_raw;

  pipe_hazard_ctrl_fwd_sel u_fwd_a (
    .src      (ID_Rs),
    .en       (1'b1),
    .ex_addr  (EX_AddrC),
    .ex_wr    (EX_RegWr),
    .mem_addr (MEM_AddrC),
    .mem_wr   (MEM_RegWr),
    .wb_addr  (WB_AddrC),
    .wb_wr    (WB_RegWr),
    .sel      (fwda_raw)
  );

  pipe_hazard_ctrl_fwd_sel u_fwd_b (
    .src      (ID_Rt),
    .en       (ID_UsesRt),
    .ex_addr  (EX_AddrC),
    .ex_wr    (EX_RegWr),
    .mem_addr (MEM_AddrC),
    .mem_wr   (MEM_RegWr),
    .wb_addr  (WB_AddrC),
    .wb_wr    (WB_RegWr),
    .sel      (fwdb_raw)
  );

  // Prioritised hazard decision; reset forces a flushed, bubbled pipeline.
  always_comb begin
    PC_Hold      = 1'b0;
    IFID_Hold    = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Hold    = 1'b0;
    IDEX_Stall   = 1'b0;
    EXMEM_Hold   = 1'b0;
    MEMWB_Bubble = 1'b0;
    IrqTake      = 1'b0;
    FwdA         = reset ? FWD_RF : fwda_raw;
    FwdB         = reset ? FWD_RF : fwdb_raw;
    irq_edge     = IRQ && !irq_prev;
    load_use     = EX_MemRd && (EX_AddrC != '0) &&
                   ((EX_AddrC == ID_Rs) || (ID_UsesRt && (EX_AddrC == ID_Rt)));
    // EX is frozen or squashed in these cases, so a pending IRQ edge waits.
    irq_upd      = !(MemBusy || EX_BranchTaken);
    tcnt_inc     = (tcnt == '1) ? tcnt : tcnt + 1'b1;

    if (reset) begin
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (MemBusy) begin
      PC_Hold      = 1'b1;
      IFID_Hold    = 1'b1;
      IDEX_Hold    = 1'b1;
      EXMEM_Hold   = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (irq_edge) begin
      IrqTake    = 1'b1;
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (load_use) begin
      PC_Hold    = 1'b1;
      IFID_Hold  = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (ID_Jump) begin
      IFID_Flush = 1'b1;
    end
  end

  // Memory-wait FSM, timeout tracking, IRQ history and performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      tcnt     <= '0;
      irq_prev <= 1'b0;
      MemErr   <= 1'b0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (irq_upd)
        irq_prev <= IRQ;

      case (state)
        RUN: begin
          if (MemBusy) begin
            state <= MEMWAIT;
            tcnt  <= TCNT_W'(1);
            if (TCNT_W'(1) >= TIMEOUT)
              MemErr <= 1'b1;
          end
        end
        MEMWAIT: begin
          if (MemBusy) begin
            tcnt <= tcnt_inc;
            if (tcnt_inc >= TIMEOUT)
              MemErr <= 1'b1;
          end else begin
            state <= RUN;
            tcnt  <= '0;
          end
        end
        default: begin
          state <= RUN;
          tcnt  <= '0;
        end
      endcase

      if (PC_Hold && StallCnt != '1)
        StallCnt <= StallCnt + 1'b1;
      if (IFID_Flush && FlushCnt != '1)
        FlushCnt <= FlushCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_AddrC, MEM_AddrC, WB_AddrC;
  logic        ID_UsesRt, EX_RegWr, EX_MemRd, MEM_RegWr, WB_RegWr;
  logic        EX_BranchTaken, ID_Jump, IRQ, MemBusy;
  logic        PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Stall;
  logic        EXMEM_Hold, MEMWB_Bubble, IrqTake, MemErr;
  logic [1:0]  FwdA, FwdB;
  logic [15:0] StallCnt, FlushCnt;
  logic [7:0]  ctl;

  int passed = 0;
  int total  = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // Control bit order: PC_Hold IFID_Hold IFID_Flush IDEX_Hold IDEX_Stall EXMEM_Hold MEMWB_Bubble IrqTake
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LDUSE = 8'b1100_1000;
  localparam logic [7:0] C_FLBUB = 8'b0010_1000;
  localparam logic [7:0] C_JUMP  = 8'b0010_0000;
  localparam logic [7:0] C_BUSY  = 8'b1101_0110;
  localparam logic [7:0] C_IRQ   = 8'b0010_1001;

  assign ctl = {PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Stall,
                EXMEM_Hold, MEMWB_Bubble, IrqTake};

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_AddrC(EX_AddrC), .EX_RegWr(EX_RegWr), .EX_MemRd(EX_MemRd),
    .MEM_AddrC(MEM_AddrC), .MEM_RegWr(MEM_RegWr),
    .WB_AddrC(WB_AddrC), .WB_RegWr(WB_RegWr),
    .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump), .IRQ(IRQ), .MemBusy(MemBusy),
    .PC_Hold(PC_Hold), .IFID_Hold(IFID_Hold), .IFID_Flush(IFID_Flush),
    .IDEX_Hold(IDEX_Hold), .IDEX_Stall(IDEX_Stall), .EXMEM_Hold(EXMEM_Hold),
    .MEMWB_Bubble(MEMWB_Bubble), .FwdA(FwdA), .FwdB(FwdB), .IrqTake(IrqTake),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
    EX_AddrC = '0; EX_RegWr = 1'b0; EX_MemRd = 1'b0;
    MEM_AddrC = '0; MEM_RegWr = 1'b0; WB_AddrC = '0; WB_RegWr = 1'b0;
    EX_BranchTaken = 1'b0; ID_Jump = 1'b0; MemBusy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IRQ = 1'b0;
    idle();
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_FLBUB));
    tick(); tick();
    chk("rst_stallcnt", 32'(StallCnt), 0);
    chk("rst_flushcnt", 32'(FlushCnt), 0);
    chk("rst_memerr", 32'(MemErr), 0);
    chk("rst_fwda", 32'(FwdA), 0);
    reset = 1'b0;
    #1;
    chk("run_idle_ctl", 32'(ctl), 32'(C_NONE));
    tick();

    // Load-use on $8 stalls once, then forwards from MEM.
    EX_MemRd = 1'b1; EX_RegWr = 1'b1; EX_AddrC = 5'd8; ID_Rs = 5'd8;
    #1;
    chk("lduse_ctl", 32'(ctl), 32'(C_LDUSE));
    chk("lduse_fwda", 32'(FwdA), 32'h1);
    tick(); exp_stall++;
    chk("lduse_stallcnt", 32'(StallCnt), 32'(exp_stall));
    EX_MemRd = 1'b0; EX_RegWr = 1'b0; EX_AddrC = '0;
    MEM_AddrC = 5'd8; MEM_RegWr = 1'b1;
    #1;
    chk("lduse_next_ctl", 32'(ctl), 32'(C_NONE));
    chk("lduse_next_fwda", 32'(FwdA), 32'h2);
    tick();
    chk("lduse_next_stallcnt", 32'(StallCnt), 32'(exp_stall));

    // Forward priority on Rt.
    idle();
    EX_AddrC = 5'd5; MEM_AddrC = 5'd5; WB_AddrC = 5'd5;
    EX_RegWr = 1'b1; MEM_RegWr = 1'b1; WB_RegWr = 1'b1;
    ID_Rt = 5'd5; ID_UsesRt = 1'b1;
    #1;
    chk("fwdb_ex", 32'(FwdB), 32'h1);
    chk("fwda_none", 32'(FwdA), 32'h0);
    EX_RegWr = 1'b0; #1;
    chk("fwdb_mem", 32'(FwdB), 32'h2);
    MEM_RegWr = 1'b0; #1;
    chk("fwdb_wb", 32'(FwdB), 32'h3);
    ID_UsesRt = 1'b0; #1;
    chk("fwdb_unused", 32'(FwdB), 32'h0);
    ID_UsesRt = 1'b1; EX_RegWr = 1'b1; MEM_RegWr = 1'b1;
    EX_AddrC = '0; MEM_AddrC = '0; WB_AddrC = '0; ID_Rt = '0;
    #1;
    chk("fwdb_r0", 32'(FwdB), 32'h0);
    chk("fwd_ctl", 32'(ctl), 32'(C_NONE));
    tick();

    // Branch beats load-use.
    idle();
    EX_MemRd = 1'b1; EX_RegWr = 1'b1; EX_AddrC = 5'd8; ID_Rs = 5'd8; EX_BranchTaken = 1'b1;
    #1;
    chk("br_lduse_ctl", 32'(ctl), 32'(C_FLBUB));
    tick(); exp_flush++;
    chk("br_flushcnt", 32'(FlushCnt), 32'(exp_flush));
    chk("br_stallcnt", 32'(StallCnt), 32'(exp_stall));

    // Jump flushes IF/ID only.
    idle(); ID_Jump = 1'b1;
    #1;
    chk("jump_ctl", 32'(ctl), 32'(C_JUMP));
    tick(); exp_flush++;
    chk("jump_flushcnt", 32'(FlushCnt), 32'(exp_flush));

    // 300-cycle memory wait; branch and IRQ edge arrive mid-wait.
    idle(); MemBusy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      EX_BranchTaken = (i == 10);
      if (i == 100) IRQ = 1'b1;
      #1;
      chk("busy_ctl", 32'(ctl), 32'(C_BUSY));
      if (i == 255) chk("memerr_pre", 32'(MemErr), 0);
      if (i == 256) chk("memerr_set", 32'(MemErr), 1);
      tick(); exp_stall++;
    end
    chk("busy_stallcnt", 32'(StallCnt), 32'(exp_stall));
    MemBusy = 1'b0;
    #1;
    chk("irq_take_ctl", 32'(ctl), 32'(C_IRQ));
    tick(); exp_flush++;
    chk("irq_flushcnt", 32'(FlushCnt), 32'(exp_flush));
    chk("memerr_sticky", 32'(MemErr), 1);
    chk("irq_once_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("irq_once_ctl2", 32'(ctl), 32'(C_NONE));
    chk("post_busy_stallcnt", 32'(StallCnt), 32'(exp_stall));

    // Reset in the middle of a memory wait.
    MemBusy = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_stallcnt", 32'(StallCnt), 0);
    chk("midrst_flushcnt", 32'(FlushCnt), 0);
    chk("midrst_memerr", 32'(MemErr), 0);
    chk("midrst_ctl", 32'(ctl), 32'(C_FLBUB));
    tick();
    chk("midrst_hold_cnt", 32'(FlushCnt), 0);
    MemBusy = 1'b0; IRQ = 1'b0;
    reset = 1'b0;
    #1;
    chk("postrst_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("postrst_stallcnt", 32'(StallCnt), 0);
    chk("postrst_memerr", 32'(MemErr), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
